// File: rtl/deserializador_alineado.sv
// Serial receiver for 10-bit symbols: hunts for a K28.5 comma, locks the
// symbol boundary to it and delivers each aligned symbol in parallel.
module deserializador_alineado #(
    parameter logic [9:0] COMMA_NEG   = 10'b0011111010,
    parameter logic [9:0] COMMA_POS   = 10'b1100000101,
    parameter int         COMMAS_SYNC = 3,
    parameter int         ERR_MAX     = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enb,
    input  logic       entrada,
    output logic [9:0] salidas,
    output logic       valido,
    output logic       alineado,
    output logic       comma_det,
    output logic       err_simbolo
);

    typedef enum logic [1:0] {
        BUSCAR    = 2'd0,
        VERIFICAR = 2'd1,
        SINC      = 2'd2
    } estado_t;

    localparam logic [2:0] NCOMMA_OBJ = 3'(COMMAS_SYNC);
    localparam logic [2:0] NERR_OBJ   = 3'(ERR_MAX);

    estado_t    estado;
    logic [9:0] sr;
    logic [3:0] cnt;
    logic [2:0] ncomma;
    logic [2:0] nerr;

    logic [9:0] sr_next;
    logic [3:0] unos;
    logic       es_comma;
    logic       es_invalido;
    logic       frontera;

    always_comb begin
        sr_next = {sr[8:0], entrada};
        unos    = 4'd0;
        for (int i = 0; i < 10; i++) begin
            unos = unos + {3'd0, sr_next[i]};
        end
        es_comma    = (sr_next == COMMA_NEG) || (sr_next == COMMA_POS);
        es_invalido = (unos < 4'd4) || (unos > 4'd6);
        frontera    = (cnt == 4'd9);
    end

    always_ff @(posedge clk) begin
        // Pulse outputs default low on every edge, including enb=0 edges.
        valido      <= 1'b0;
        comma_det   <= 1'b0;
        err_simbolo <= 1'b0;
        if (rst) begin
            estado   <= BUSCAR;
            sr       <= 10'd0;
            cnt      <= 4'd0;
            ncomma   <= 3'd0;
            nerr     <= 3'd0;
            salidas  <= 10'd0;
            alineado <= 1'b0;
        end else if (enb) begin
            sr  <= sr_next;
            cnt <= frontera ? 4'd0 : cnt + 4'd1;
            case (estado)
                BUSCAR: begin
                    if (es_comma) begin
                        cnt    <= 4'd0;
                        ncomma <= 3'd1;
                        if (COMMAS_SYNC == 1) begin
                            estado    <= SINC;
                            alineado  <= 1'b1;
                            nerr      <= 3'd0;
                            salidas   <= sr_next;
                            valido    <= 1'b1;
                            comma_det <= 1'b1;
                        end else begin
                            estado <= VERIFICAR;
                        end
                    end
                end
                VERIFICAR: begin
                    if (frontera) begin
                        if (es_comma) begin
                            ncomma <= ncomma + 3'd1;
                            if (ncomma + 3'd1 == NCOMMA_OBJ) begin
                                estado    <= SINC;
                                alineado  <= 1'b1;
                                nerr      <= 3'd0;
                                salidas   <= sr_next;
                                valido    <= 1'b1;
                                comma_det <= 1'b1;
                            end
                        end else begin
                            estado <= BUSCAR;
                            ncomma <= 3'd0;
                        end
                    end
                end
                SINC: begin
                    if (frontera) begin
                        salidas     <= sr_next;
                        valido      <= 1'b1;
                        comma_det   <= es_comma;
                        err_simbolo <= es_invalido;
                        if (es_invalido) begin
                            if (nerr + 3'd1 == NERR_OBJ) begin
                                // Lock lost: the failing symbol is still delivered.
                                estado   <= BUSCAR;
                                alineado <= 1'b0;
                                cnt      <= 4'd0;
                                ncomma   <= 3'd0;
                                nerr     <= 3'd0;
                            end else begin
                                nerr <= nerr + 3'd1;
                            end
                        end else begin
                            nerr <= 3'd0;
                        end
                    end
                end
                default: begin
                    estado <= BUSCAR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_deserializador_alineado.sv
// Self-checking bench for deserializador_alineado: symbol table plus
// hand-written sequences, with an expected-output queue for delivered symbols.
module tb_deserializador_alineado;

    localparam logic [9:0] CN = 10'b0011111010;
    localparam logic [9:0] CP = 10'b1100000101;
    localparam int W = 12;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       enb = 1'b0;
    logic       entrada = 1'b0;
    logic [9:0] salidas;
    logic       valido;
    logic       alineado;
    logic       comma_det;
    logic       err_simbolo;

    int n_checks = 0;
    int n_errors = 0;

    logic [W-1:0] exp_q[$];

    typedef struct {
        logic [9:0] sym;
        logic       dlv;
        logic       cm;
        logic       er;
        logic       aln;
    } vec_t;

    vec_t tabla[17];

    deserializador_alineado dut (
        .clk(clk),
        .rst(rst),
        .enb(enb),
        .entrada(entrada),
        .salidas(salidas),
        .valido(valido),
        .alineado(alineado),
        .comma_det(comma_det),
        .err_simbolo(err_simbolo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nombre, input logic [15:0] act, input logic [15:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nombre, act, req, $time);
        end
    endtask

    // One clock: drive inputs, wait for the edge, sample 1 time unit later.
    task automatic paso(input logic b, input logic en, input logic exp_valido);
        logic [W-1:0] e;
        entrada = b;
        enb     = en;
        @(posedge clk);
        #1;
        chk("valido", {15'd0, valido}, {15'd0, exp_valido});
        if (exp_valido) begin
            if (exp_q.size() == 0) begin
                chk("exp_q_vacia", 16'd1, 16'd0);
            end else begin
                e = exp_q.pop_front();
                chk("salidas", {6'd0, salidas}, {6'd0, e[11:2]});
                chk("comma_det", {15'd0, comma_det}, {15'd0, e[1]});
                chk("err_simbolo", {15'd0, err_simbolo}, {15'd0, e[0]});
            end
        end else begin
            chk("pulsos_sin_valido", {14'd0, comma_det, err_simbolo}, 16'd0);
        end
    endtask

    task automatic enviar(input logic [9:0] sym, input logic dlv, input logic cm,
                          input logic er, input logic aln);
        for (int i = 9; i >= 0; i--) begin
            if (i == 0 && dlv) exp_q.push_back({sym, cm, er});
            paso(sym[i], 1'b1, (i == 0) && dlv);
        end
        chk("alineado", {15'd0, alineado}, {15'd0, aln});
    endtask

    initial begin
        logic [9:0] s;
        int consec;

        // Reset with random serial data.
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            entrada = 1'($urandom_range(0, 1));
            enb     = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            chk("reset_salidas", {6'd0, salidas}, 16'd0);
            chk("reset_pulsos", {13'd0, valido, comma_det, err_simbolo}, 16'd0);
            chk("reset_alineado", {15'd0, alineado}, 16'd0);
        end
        rst = 1'b0;

        tabla[0]  = '{CN, 1'b0, 1'b0, 1'b0, 1'b0};
        tabla[1]  = '{CP, 1'b0, 1'b0, 1'b0, 1'b0};
        tabla[2]  = '{CN, 1'b1, 1'b1, 1'b0, 1'b1};
        tabla[3]  = '{10'b0000011111, 1'b1, 1'b0, 1'b0, 1'b1};
        tabla[4]  = '{10'b1111111110, 1'b1, 1'b0, 1'b1, 1'b1};
        tabla[5]  = '{10'b1111111110, 1'b1, 1'b0, 1'b1, 1'b1};
        tabla[6]  = '{10'b1111111110, 1'b1, 1'b0, 1'b1, 1'b1};
        tabla[7]  = '{10'b1010110010, 1'b1, 1'b0, 1'b0, 1'b1};
        tabla[8]  = '{10'b0000000001, 1'b1, 1'b0, 1'b1, 1'b1};
        tabla[9]  = '{10'b0000000001, 1'b1, 1'b0, 1'b1, 1'b1};
        tabla[10] = '{10'b0000000001, 1'b1, 1'b0, 1'b1, 1'b1};
        tabla[11] = '{10'b0000000001, 1'b1, 1'b0, 1'b1, 1'b0};
        tabla[12] = '{CN, 1'b0, 1'b0, 1'b0, 1'b0};
        tabla[13] = '{10'b1010010101, 1'b0, 1'b0, 1'b0, 1'b0};
        tabla[14] = '{CN, 1'b0, 1'b0, 1'b0, 1'b0};
        tabla[15] = '{CP, 1'b0, 1'b0, 1'b0, 1'b0};
        tabla[16] = '{CN, 1'b1, 1'b1, 1'b0, 1'b1};

        // Garbage prefix 101, then the symbol table.
        paso(1'b1, 1'b1, 1'b0);
        paso(1'b0, 1'b1, 1'b0);
        paso(1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 17; k++) begin
            enviar(tabla[k].sym, tabla[k].dlv, tabla[k].cm, tabla[k].er, tabla[k].aln);
            if (k == 12) chk("salidas_tras_perdida", {6'd0, salidas}, 16'h0001);
        end

        // Random symbols while locked, never reaching the error limit.
        consec = 0;
        for (int k = 0; k < 10; k++) begin
            s = 10'($urandom_range(0, 1023));
            if (consec == 3) s = 10'b0110100101;
            if ($countones(s) < 4 || $countones(s) > 6) consec++;
            else consec = 0;
            enviar(s, 1'b1, (s == CN) || (s == CP),
                   ($countones(s) < 4) || ($countones(s) > 6), 1'b1);
        end

        // enb gap of 7 clocks inside a symbol.
        s = 10'b1100101100;
        for (int i = 9; i >= 5; i--) paso(s[i], 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) paso(1'($urandom_range(0, 1)), 1'b0, 1'b0);
        for (int i = 4; i >= 0; i--) begin
            if (i == 0) exp_q.push_back({s, 1'b0, 1'b0});
            paso(s[i], 1'b1, i == 0);
        end
        chk("alineado_tras_gap", {15'd0, alineado}, 16'd1);

        // Reset five bits into a symbol while locked.
        s = 10'b1011001010;
        for (int i = 9; i >= 5; i--) paso(s[i], 1'b1, 1'b0);
        rst = 1'b1;
        paso(1'b1, 1'b1, 1'b0);
        rst = 1'b0;
        chk("rst_alineado", {15'd0, alineado}, 16'd0);
        chk("rst_salidas", {6'd0, salidas}, 16'd0);
        enviar(CN, 1'b0, 1'b0, 1'b0, 1'b0);
        enviar(CN, 1'b0, 1'b0, 1'b0, 1'b0);
        enviar(CN, 1'b1, 1'b1, 1'b0, 1'b1);
        enviar(10'b0101011010, 1'b1, 1'b0, 1'b0, 1'b1);

        chk("exp_q_final", 16'(exp_q.size()), 16'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
